// File: rtl/fpu_unit.sv
// rtl/fpu_unit.sv - binary32 adder/subtractor, round-to-nearest-even, NUM_OP output register stages
module fpu_unit #(
    parameter int NUM_OP = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_add_sub,
    input  logic [31:0] i_32_a,
    input  logic [31:0] i_32_b,
    output logic [31:0] o_32_s,
    output logic        o_ov_flag,
    output logic        o_un_flag
);

    logic        sign_a, sign_b;
    logic [7:0]  exp_a, exp_b, exp_a_eff, exp_b_eff;
    logic [22:0] frac_a, frac_b;
    logic [23:0] sig_a, sig_b;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    assign sign_a    = i_32_a[31];
    assign sign_b    = i_32_b[31] ^ i_add_sub;
    assign exp_a     = i_32_a[30:23];
    assign exp_b     = i_32_b[30:23];
    assign frac_a    = i_32_a[22:0];
    assign frac_b    = i_32_b[22:0];
    assign exp_a_eff = (exp_a == 8'd0) ? 8'd1 : exp_a;
    assign exp_b_eff = (exp_b == 8'd0) ? 8'd1 : exp_b;
    assign sig_a     = {exp_a != 8'd0, frac_a};
    assign sig_b     = {exp_b != 8'd0, frac_b};
    assign nan_a     = (exp_a == 8'hFF) && (frac_a != 23'd0);
    assign nan_b     = (exp_b == 8'hFF) && (frac_b != 23'd0);
    assign inf_a     = (exp_a == 8'hFF) && (frac_a == 23'd0);
    assign inf_b     = (exp_b == 8'hFF) && (frac_b == 23'd0);
    assign zero_a    = (i_32_a[30:0] == 31'd0);
    assign zero_b    = (i_32_b[30:0] == 31'd0);

    // Bit patterns of non-negative floats order the same way as their magnitudes.
    logic        a_ge_b;
    logic        big_sign;
    logic [7:0]  big_exp, small_exp, exp_diff;
    logic [23:0] big_sig, small_sig;

    assign a_ge_b    = (i_32_a[30:0] >= i_32_b[30:0]);
    assign big_sign  = a_ge_b ? sign_a : sign_b;
    assign big_exp   = a_ge_b ? exp_a_eff : exp_b_eff;
    assign small_exp = a_ge_b ? exp_b_eff : exp_a_eff;
    assign big_sig   = a_ge_b ? sig_a : sig_b;
    assign small_sig = a_ge_b ? sig_b : sig_a;
    assign exp_diff  = big_exp - small_exp;

    logic [26:0] small_ext, shift_mask, aligned;

    always_comb begin
        small_ext  = {small_sig, 3'b000};
        shift_mask = '0;
        aligned    = '0;
        if (exp_diff >= 8'd26) begin
            aligned = 27'd1;
        end else begin
            shift_mask = (27'd1 << exp_diff[4:0]) - 27'd1;
            aligned    = small_ext >> exp_diff[4:0];
            aligned[0] = aligned[0] | (|(small_ext & shift_mask));
        end
    end

    logic        eff_sub;
    logic [27:0] big_ext, raw_sum;

    assign eff_sub = sign_a ^ sign_b;
    assign big_ext = {1'b0, big_sig, 3'b000};
    assign raw_sum = eff_sub ? (big_ext - {1'b0, aligned}) : (big_ext + {1'b0, aligned});

    logic [4:0] lzc;

    always_comb begin
        lzc = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (raw_sum[i]) lzc = 5'(26 - i);
        end
    end

    // Left shift stops at exponent 1 so tiny results come out subnormal.
    logic [7:0]  max_shift, lshift;
    logic [26:0] norm_mant;
    logic [9:0]  norm_exp;

    always_comb begin
        max_shift = big_exp - 8'd1;
        lshift    = '0;
        norm_mant = '0;
        norm_exp  = '0;
        if (raw_sum[27]) begin
            norm_mant = {raw_sum[27:2], raw_sum[1] | raw_sum[0]};
            norm_exp  = {2'b00, big_exp} + 10'd1;
        end else begin
            lshift    = ({3'b000, lzc} > max_shift) ? max_shift : {3'b000, lzc};
            norm_mant = raw_sum[26:0] << lshift;
            norm_exp  = {2'b00, big_exp - lshift};
        end
    end

    logic        round_up;
    logic [24:0] rounded;
    logic [9:0]  fin_exp;
    logic [22:0] fin_frac;

    assign round_up = norm_mant[2] & (norm_mant[1] | norm_mant[0] | norm_mant[3]);
    assign rounded  = {1'b0, norm_mant[26:3]} + {24'd0, round_up};

    always_comb begin
        fin_exp  = '0;
        fin_frac = '0;
        if (rounded[24]) begin
            fin_exp  = norm_exp + 10'd1;
            fin_frac = rounded[23:1];
        end else if (rounded[23]) begin
            fin_exp  = norm_exp;
            fin_frac = rounded[22:0];
        end else begin
            fin_exp  = 10'd0;
            fin_frac = rounded[22:0];
        end
    end

    logic [31:0] res_s;
    logic        res_ov, res_un;

    always_comb begin
        res_s  = '0;
        res_ov = 1'b0;
        res_un = 1'b0;
        if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) begin
            res_s = 32'h7FC0_0000;
        end else if (inf_a) begin
            res_s = {sign_a, 31'h7F80_0000};
        end else if (inf_b) begin
            res_s = {sign_b, 31'h7F80_0000};
        end else if (zero_a && zero_b) begin
            res_s = {sign_a & sign_b, 31'd0};
        end else if (zero_a) begin
            res_s = {sign_b, i_32_b[30:0]};
        end else if (zero_b) begin
            res_s = i_32_a;
        end else if (raw_sum == 28'd0) begin
            res_s = 32'h0000_0000;
        end else if (fin_exp >= 10'd255) begin
            res_s  = {big_sign, 31'h7F80_0000};
            res_ov = 1'b1;
        end else begin
            res_s  = {big_sign, fin_exp[7:0], fin_frac};
            res_un = (fin_exp == 10'd0);
        end
    end

    logic [NUM_OP-1:0][31:0] s_pipe;
    logic [NUM_OP-1:0]       ov_pipe, un_pipe;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s_pipe  <= '0;
            ov_pipe <= '0;
            un_pipe <= '0;
        end else begin
            s_pipe[0]  <= res_s;
            ov_pipe[0] <= res_ov;
            un_pipe[0] <= res_un;
            for (int k = 1; k < NUM_OP; k++) begin
                s_pipe[k]  <= s_pipe[k-1];
                ov_pipe[k] <= ov_pipe[k-1];
                un_pipe[k] <= un_pipe[k-1];
            end
        end
    end

    assign o_32_s    = s_pipe[NUM_OP-1];
    assign o_ov_flag = ov_pipe[NUM_OP-1];
    assign o_un_flag = un_pipe[NUM_OP-1];

endmodule

// File: tb/tb_fpu_unit.sv
// tb/tb_fpu_unit.sv - fpu_unit bench: exact-integer reference model, per-cycle compare, directed vectors
module tb_fpu_unit;

    localparam int NUM_OP = 2;
    localparam int NVEC   = 30;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_add_sub;
    logic [31:0] i_32_a, i_32_b;
    logic [31:0] o_32_s;
    logic        o_ov_flag, o_un_flag;

    int checks   = 0;
    int failures = 0;

    fpu_unit #(.NUM_OP(NUM_OP)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_add_sub(i_add_sub),
        .i_32_a   (i_32_a),
        .i_32_b   (i_32_b),
        .o_32_s   (o_32_s),
        .o_ov_flag(o_ov_flag),
        .o_un_flag(o_un_flag)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic        ov;
        logic        un;
    } vec_t;

    function automatic vec_t get_vec(input int i);
        case (i)
            0:  return {1'b0, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0};
            1:  return {1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0};
            2:  return {1'b1, 32'h4016A197, 32'h4016A197, 32'h00000000, 1'b0, 1'b0};
            3:  return {1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0};
            4:  return {1'b1, 32'h7F800000, 32'h40533333, 32'h7F800000, 1'b0, 1'b0};
            5:  return {1'b1, 32'hFF800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0};
            6:  return {1'b0, 32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0};
            7:  return {1'b0, 32'hC00CCCCD, 32'h40533333, 32'h3F8CCCCC, 1'b0, 1'b0};
            8:  return {1'b1, 32'hC00CCCCD, 32'hC0533333, 32'h3F8CCCCC, 1'b0, 1'b0};
            9:  return {1'b0, 32'h40533333, 32'hC00CCCCD, 32'h3F8CCCCC, 1'b0, 1'b0};
            10: return {1'b0, 32'h7F7FFFFF, 32'h00FFFFFF, 32'h7F7FFFFF, 1'b0, 1'b0};
            11: return {1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0};
            12: return {1'b0, 32'h00FFFFFF, 32'h007FFFFF, 32'h013FFFFF, 1'b0, 1'b0};
            13: return {1'b1, 32'h00FFFFFF, 32'h007FFFFF, 32'h00800000, 1'b0, 1'b0};
            14: return {1'b1, 32'h00800001, 32'h00800000, 32'h00000001, 1'b0, 1'b1};
            15: return {1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0};
            16: return {1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0};
            17: return {1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0, 1'b0};
            18: return {1'b0, 32'h3F800000, 32'h33800001, 32'h3F800001, 1'b0, 1'b0};
            19: return {1'b1, 32'h3F800000, 32'h33000000, 32'h3F800000, 1'b0, 1'b0};
            20: return {1'b1, 32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 1'b0, 1'b0};
            21: return {1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0};
            22: return {1'b1, 32'h00000000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0};
            23: return {1'b0, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 1'b1, 1'b0};
            24: return {1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
            25: return {1'b0, 32'h00000001, 32'h80000001, 32'h00000000, 1'b0, 1'b0};
            26: return {1'b0, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b1};
            27: return {1'b0, 32'h00400000, 32'h00400000, 32'h00800000, 1'b0, 1'b0};
            28: return {1'b1, 32'h41200000, 32'h3F800000, 32'h41100000, 1'b0, 1'b0};
            default: return {1'b0, 32'h4B7FFFFF, 32'h3F000000, 32'h4B800000, 1'b0, 1'b0};
        endcase
    endfunction

    // Exact sum in units of 2^-149, then rounded to binary32 by integer arithmetic.
    function automatic logic [33:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic         sa, sb, rs, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [299:0] ma, mb, mag, q, rem, half;
        int           ea, eb, p, sh, e;
        sa = a[31];
        sb = b[31] ^ op;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_zero = (a[30:0] == 0);
        b_zero = (b[30:0] == 0);
        if (a_nan || b_nan || (a_inf && b_inf && sa != sb)) return {32'h7FC00000, 2'b00};
        if (a_inf) return {sa, 31'h7F800000, 2'b00};
        if (b_inf) return {sb, 31'h7F800000, 2'b00};
        if (a_zero && b_zero) return {sa & sb, 31'd0, 2'b00};
        if (a_zero) return {sb, b[30:0], 2'b00};
        if (b_zero) return {a, 2'b00};
        ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
        ma = 300'({a[30:23] != 8'd0, a[22:0]}) << (ea - 1);
        mb = 300'({b[30:23] != 8'd0, b[22:0]}) << (eb - 1);
        if (sa == sb) begin
            mag = ma + mb; rs = sa;
        end else if (ma >= mb) begin
            mag = ma - mb; rs = sa;
        end else begin
            mag = mb - ma; rs = sb;
        end
        if (mag == 0) return 34'd0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p <= 23) return {rs, (p == 23) ? 8'd1 : 8'd0, mag[22:0], 1'b0, p < 23};
        sh   = p - 23;
        q    = mag >> sh;
        rem  = mag - (q << sh);
        half = 300'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q[24]) begin
            q  = q >> 1;
            sh = sh + 1;
        end
        e = sh + 1;
        if (e >= 255) return {rs, 31'h7F800000, 2'b10};
        return {rs, 8'(e), q[22:0], 2'b00};
    endfunction

    logic [33:0] cur_exp;
    logic [33:0] exp_pipe [NUM_OP];
    logic        armed = 1'b0;

    assign cur_exp = model(i_add_sub, i_32_a, i_32_b);

    always @(posedge i_clk) begin
        armed <= 1'b1;
        if (i_rst) begin
            for (int k = 0; k < NUM_OP; k++) exp_pipe[k] <= '0;
        end else begin
            exp_pipe[0] <= cur_exp;
            for (int k = 1; k < NUM_OP; k++) exp_pipe[k] <= exp_pipe[k-1];
        end
    end

    initial begin
        vec_t        v;
        logic [33:0] r;
        for (int i = 0; i < NVEC; i++) begin
            v = get_vec(i);
            r = model(v.op, v.a, v.b);
            checks++;
            if (r !== {v.s, v.ov, v.un}) begin
                failures++;
                $display("FAIL model_vec%0d a=%08h b=%08h op=%0b got s=%08h ov=%0b un=%0b need s=%08h ov=%0b un=%0b",
                         i, v.a, v.b, v.op, r[33:2], r[1], r[0], v.s, v.ov, v.un);
            end
        end
        forever begin
            @(negedge i_clk);
            if (armed) begin
                checks++;
                if ({o_32_s, o_ov_flag, o_un_flag} !== exp_pipe[NUM_OP-1]) begin
                    failures++;
                    $display("FAIL dut_out t=%0t got s=%08h ov=%0b un=%0b need s=%08h ov=%0b un=%0b",
                             $time, o_32_s, o_ov_flag, o_un_flag, exp_pipe[NUM_OP-1][33:2],
                             exp_pipe[NUM_OP-1][1], exp_pipe[NUM_OP-1][0]);
                end
            end
        end
    end

    task automatic apply(input logic rst, input logic op, input logic [31:0] a, input logic [31:0] b);
        @(posedge i_clk);
        #1;
        i_rst     = rst;
        i_add_sub = op;
        i_32_a    = a;
        i_32_b    = b;
    endtask

    initial begin
        vec_t v;
        i_rst     = 1'b1;
        i_add_sub = 1'b0;
        i_32_a    = 32'h3F800000;
        i_32_b    = 32'h3F800000;
        repeat (3) @(posedge i_clk);
        apply(1'b0, 1'b0, 32'h3F800000, 32'h3F800000);
        repeat (NUM_OP) @(posedge i_clk);
        #1;
        checks++;
        if (o_32_s !== 32'h40000000) begin
            failures++;
            $display("FAIL latency_1p1 got %08h need 40000000", o_32_s);
        end
        for (int i = 0; i < NVEC; i++) begin
            v = get_vec(i);
            apply(1'b0, v.op, v.a, v.b);
            if (i == 12) apply(1'b1, 1'b0, 32'h3F800000, 32'h3F800000);
        end
        for (int i = NVEC - 1; i >= 0; i--) begin
            v = get_vec(i);
            apply(1'b0, v.op, v.a, v.b);
        end
        repeat (NUM_OP + 2) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
